// File: rtl/core_mdu_seq.sv
// core_mdu_seq: iterative RV64M multiply/divide unit for EXU.
// Multiplies by shift-add and divides by restoring division, one bit per cycle.
// Divide-by-zero and signed overflow resolve in a single cycle.
module core_mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic            op_w_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int MAG_W  = XLEN + 1;
  localparam int PROD_W = 2 * XLEN;
  localparam int CNT_W  = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]        funct3_q, funct3_d;
  logic              op_w_q, op_w_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MAG_W-1:0]  mplier_q, mplier_d;
  logic [MAG_W-1:0]  dvsr_q, dvsr_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [MAG_W-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, sgn_a, sgn_b, zext_w, neg_a, neg_b;
  logic              div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   a_ext, b_ext, spec_res;
  logic [MAG_W-1:0]  mag_a, mag_b;

  logic [PROD_W-1:0] acc_nx;
  logic [MAG_W-1:0]  rem_sh, rem_nx;
  logic [MAG_W:0]    diff;
  logic              q_bit;
  logic [XLEN-1:0]   quo_nx;

  // Replicate bit 31 across the upper word for W-variant results.
  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Sign-correct the raw magnitudes and pick the architectural result.
  function automatic logic [XLEN-1:0] finish_res(
    input logic [2:0]        f3,
    input logic              w,
    input logic              na,
    input logic              nb,
    input logic [PROD_W-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    logic [PROD_W-1:0] prod_s;
    logic [XLEN-1:0]   r;
    prod_s = (na ^ nb) ? -prod : prod;
    case (f3)
      3'b000:                 r = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: r = w ? (prod_s[XLEN-1:0] >> 32) : prod_s[PROD_W-1:XLEN];
      3'b100, 3'b101:         r = (na ^ nb) ? -quo : quo;
      default:                r = na ? -rem : rem;
    endcase
    return w ? sext_w(r[31:0]) : r;
  endfunction

  // Operand conditioning for the op offered in IDLE: extension, signs, magnitudes, special cases.
  always_comb begin
    is_div = funct3_i[2];
    sgn_a  = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    sgn_b  = is_div ? ~funct3_i[0] : ~funct3_i[1];
    zext_w = is_div & funct3_i[0];
    a_ext  = src1_i;
    b_ext  = src2_i;
    if (op_w_i) begin
      a_ext = zext_w ? {{(XLEN-32){1'b0}}, src1_i[31:0]} : sext_w(src1_i[31:0]);
      b_ext = zext_w ? {{(XLEN-32){1'b0}}, src2_i[31:0]} : sext_w(src2_i[31:0]);
    end
    neg_a    = sgn_a & a_ext[XLEN-1];
    neg_b    = sgn_b & b_ext[XLEN-1];
    // Extra magnitude bit keeps |most-negative| representable.
    mag_a    = neg_a ? -{1'b1, a_ext} : {1'b0, a_ext};
    mag_b    = neg_b ? -{1'b1, b_ext} : {1'b0, b_ext};
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & ~funct3_i[0] & (&b_ext) & (a_ext == (op_w_i ? MIN_W : MIN_X));
    special  = div_zero | div_ovf;
    if (funct3_i[1]) spec_res = div_zero ? a_ext : '0;
    else             spec_res = div_zero ? '1 : a_ext;
    if (op_w_i) spec_res = sext_w(spec_res[31:0]);
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    acc_nx = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh = MAG_W'({rem_q, quo_q[XLEN-1]});
    diff   = {1'b0, rem_sh} - {1'b0, dvsr_q};
    q_bit  = ~diff[MAG_W];
    rem_nx = q_bit ? MAG_W'(diff) : rem_sh;
    quo_nx = {quo_q[XLEN-2:0], q_bit};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt_q == '0) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy_o  = (state_q != S_IDLE);
    stall_o = ((state_q == S_IDLE) & start_i & ~flush_i) | (state_q == S_CALC);
    done_o  = (state_q == S_DONE);
  end

  // Datapath next values: load on accept, iterate in CALC, register result entering DONE.
  always_comb begin
    accept   = (state_q == S_IDLE) & start_i & ~flush_i;
    funct3_d = funct3_q;
    op_w_d   = op_w_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (accept) begin
      funct3_d = funct3_i;
      op_w_d   = op_w_i;
      neg_a_d  = neg_a;
      neg_b_d  = neg_b;
      cnt_d    = op_w_i ? CNT_W'(31) : CNT_W'(XLEN-1);
      acc_d    = '0;
      mcand_d  = {{(PROD_W-MAG_W){1'b0}}, mag_b};
      mplier_d = mag_a;
      dvsr_d   = mag_b;
      // W dividends are left-justified so the next dividend bit is always the MSB.
      quo_d    = op_w_i ? {mag_a[31:0], 32'b0} : mag_a[XLEN-1:0];
      rem_d    = '0;
      if (special) result_d = spec_res;
    end else if ((state_q == S_CALC) && !flush_i) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      quo_d    = quo_nx;
      rem_d    = rem_nx;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == '0)
        result_d = finish_res(funct3_q, op_w_q, neg_a_q, neg_b_q, acc_nx, quo_nx, rem_nx[XLEN-1:0]);
    end
  end

  // Control registers and the architectural result, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Iteration datapath registers; contents are don't-care until an op is accepted.
  always_ff @(posedge clk) begin
    funct3_q <= funct3_d;
    op_w_q   <= op_w_d;
    neg_a_q  <= neg_a_d;
    neg_b_q  <= neg_b_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    dvsr_q   <= dvsr_d;
    quo_q    <= quo_d;
    rem_q    <= rem_d;
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_core_mdu_seq.sv
// tb_core_mdu_seq: directed and randomized checks of core_mdu_seq against an
// arithmetic reference model and a cycle-level occupancy model.
module tb_core_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic        op_w_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [63:0] result_o;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: cycles left in the current op (0 = idle, 1 = done cycle).
  int          left = 0;
  logic [63:0] exp_res = 64'd0;
  logic [63:0] pend_res = 64'd0;

  core_mdu_seq #(.XLEN(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .op_w_i   (op_w_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
  endtask

  // RV64M architectural result from plain arithmetic.
  function automatic logic [63:0] ref_mdu(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ps;
    logic [127:0]        pu;
    logic [63:0]         r;
    logic [31:0]         a32, b32, r32;
    r = 64'd0;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = 32'd0;
    if (!w) begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
        3'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = ps[127:64]; end
        3'd3: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
        3'd4: begin
          if (b == 64'd0) r = '1;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else r = $signed(a) / $signed(b);
        end
        3'd5: begin
          if (b == 64'd0) r = '1;
          else r = a / b;
        end
        3'd6: begin
          if (b == 64'd0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 64'd0;
          else r = $signed(a) % $signed(b);
        end
        default: begin
          if (b == 64'd0) r = a;
          else r = a % b;
        end
      endcase
    end else begin
      case (f3)
        3'd0: r32 = a32 * b32;
        3'd4: begin
          if (b32 == 32'd0) r32 = '1;
          else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
          else r32 = $signed(a32) / $signed(b32);
        end
        3'd5: begin
          if (b32 == 32'd0) r32 = '1;
          else r32 = a32 / b32;
        end
        3'd6: begin
          if (b32 == 32'd0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 32'd0;
          else r32 = $signed(a32) % $signed(b32);
        end
        3'd7: begin
          if (b32 == 32'd0) r32 = a32;
          else r32 = a32 % b32;
        end
        default: r32 = 32'd0;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  // Single-cycle cases: any divide by zero, or signed most-negative / -1.
  function automatic logic is_special(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (!f3[2]) return 1'b0;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = (f3 == 3'd4 || f3 == 3'd6) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == '1));
    return zero | ovf;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'd1;
      4: return {$urandom, 32'h8000_0000};
      5: return {32'd0, $urandom};
      6: return {$urandom, 32'hFFFF_FFFF};
      7: return {$urandom, 32'd0};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Cycle-level model and per-cycle comparison of every output.
  always @(posedge clk) begin
    if (!rst_n) begin
      left = 0;
      exp_res = 64'd0;
    end else if (flush_i) begin
      left = 0;
    end else if (left == 0) begin
      if (start_i) begin
        pend_res = ref_mdu(funct3_i, op_w_i, src1_i, src2_i);
        left = is_special(funct3_i, op_w_i, src1_i, src2_i) ? 1 : (op_w_i ? 33 : 65);
        if (left == 1) exp_res = pend_res;
      end
    end else begin
      left--;
      if (left == 1) exp_res = pend_res;
    end
    #1;
    chk("cyc_busy",   {63'd0, busy_o},  {63'd0, (left > 0)});
    chk("cyc_done",   {63'd0, done_o},  {63'd0, (left == 1)});
    chk("cyc_stall",  {63'd0, stall_o}, {63'd0, ((left == 0 && start_i && !flush_i) || left > 1)});
    chk("cyc_result", result_o, exp_res);
  end

  task automatic run_op(input string nm, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_r, input int exp_lat, input int exp_stall);
    int lat, stalls, guard;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    funct3_i = f3; op_w_i = w; src1_i = a; src2_i = b; start_i = 1'b1;
    #1;
    stalls = stall_o ? 1 : 0;
    lat = 0;
    for (int i = 1; i <= 100 && lat == 0; i++) begin
      @(posedge clk);
      #2;
      if (stall_o) stalls++;
      if (done_o) lat = i;
      @(negedge clk);
      start_i = 1'b0;
    end
    chk({nm, "_result"}, result_o, exp_r);
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_stall > 0) chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
  endtask

  logic [2:0] wops [5];

  initial begin
    wops[0] = 3'd0; wops[1] = 3'd4; wops[2] = 3'd5; wops[3] = 3'd6; wops[4] = 3'd7;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; op_w_i = 1'b0; src1_i = 64'd0; src2_i = 64'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);

    run_op("mul",    3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 65);
    run_op("mulhu",  3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    run_op("mulh",   3'd1, 1'b0, '1, '1, 64'd0, 65, 0);
    run_op("div",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu0",  3'd5, 1'b0, 64'd5, 64'd0, '1, 1, 1);
    run_op("remu0",  3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("divuw",  3'd5, 1'b1, 64'h1_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 33);
    run_op("mulw",   3'd0, 1'b1, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33, 0);

    // Flush ten cycles into a divide.
    @(negedge clk);
    funct3_i = 3'd4; op_w_i = 1'b0; src1_i = 64'd1000; src2_i = 64'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #2;
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    chk("flush_done", {63'd0, done_o}, 64'd0);
    chk("flush_result_held", result_o, 64'hFFFF_FFFF_8000_0000);
    @(negedge clk);
    flush_i = 1'b0;
    run_op("after_flush_rem", 3'd6, 1'b0, 64'd1000, 64'd7, 64'd6, 65, 0);

    // Reset in the middle of CALC.
    @(negedge clk);
    funct3_i = 3'd3; op_w_i = 1'b0; src1_i = '1; src2_i = '1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("midreset_result", result_o, 64'd0);
    chk("midreset_busy", {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; the per-cycle model does the checking.
    for (int c = 0; c < 9000; c++) begin
      @(negedge clk);
      start_i  = ($urandom_range(0, 1) == 1);
      flush_i  = ($urandom_range(0, 199) == 0);
      rst_n    = ($urandom_range(0, 2999) != 0);
      op_w_i   = ($urandom_range(0, 2) == 0);
      funct3_i = op_w_i ? wops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      src1_i   = pick();
      src2_i   = pick();
    end
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0; rst_n = 1'b1;
    repeat (80) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
